// File: rtl/gam_edge_age_engine.sv
// Per-class symmetric edge presence/age memory for the GAM learning layer.
// Serves CONNECT, AGE, QUERY and CLEAR_CLASS over a valid/ready command port.
module gam_edge_age_engine #(
  parameter int CLASS_COUNT = 5,
  parameter int NODE_COUNT  = 50,
  parameter int AGE_MAX     = 6,
  parameter int AGE_W       = $clog2(AGE_MAX + 2),
  parameter int NODE_W      = $clog2(NODE_COUNT + 1),
  parameter int CLASS_W     = $clog2(CLASS_COUNT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [CLASS_W-1:0] cmd_class,
  input  logic [NODE_W-1:0]  cmd_node_a,
  input  logic [NODE_W-1:0]  cmd_node_b,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic               rsp_present,
  output logic [AGE_W-1:0]   rsp_age,
  output logic [NODE_W-1:0]  rsp_pruned,
  output logic               rsp_isolated,
  output logic               busy
);

  // state       | meaning
  // S_IDLE      | cmd_ready high, waiting for a command
  // S_SWEEP_AGE | ageing / pruning row of the winner node, one neighbour per cycle
  // S_SWEEP_CLR | clearing row and column i of a class, one i per cycle
  // S_RESP      | response pulse on the outputs, back to idle next cycle
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SWEEP_AGE = 2'd1,
    S_SWEEP_CLR = 2'd2,
    S_RESP      = 2'd3
  } state_t;

  localparam logic [1:0] OP_CONNECT = 2'd0;
  localparam logic [1:0] OP_AGE     = 2'd1;
  localparam logic [1:0] OP_QUERY   = 2'd2;
  localparam logic [1:0] OP_CLEAR   = 2'd3;

  localparam logic [CLASS_W-1:0] CLASS_LAST = CLASS_W'(CLASS_COUNT);
  localparam logic [NODE_W-1:0]  NODE_LAST  = NODE_W'(NODE_COUNT);
  localparam logic [AGE_W-1:0]   AGE_LIMIT  = AGE_W'(AGE_MAX);
  localparam logic [CLASS_W:0]   CLASS_END  = (CLASS_W + 1)'(CLASS_COUNT);
  localparam logic [NODE_W:0]    NODE_END   = (NODE_W + 1)'(NODE_COUNT);

  // Index 0 of every dimension is never written (indices are 1-based).
  logic [NODE_COUNT:0]            present_m [CLASS_COUNT+1][NODE_COUNT+1];
  logic [NODE_COUNT:0][AGE_W-1:0] age_m     [CLASS_COUNT+1][NODE_COUNT+1];

  state_t             state;
  logic [CLASS_W-1:0] class_q;
  logic [NODE_W-1:0]  row_q;
  logic [NODE_W-1:0]  ptr_q;
  logic [NODE_W-1:0]  pruned_q;
  logic               alive_q;

  logic              class_bad, a_bad, b_bad, a_used, b_used, cmd_err;
  logic              cur_present, prune_hit, keep_hit, alive_next;
  logic [AGE_W-1:0]  age_next;
  logic [NODE_W-1:0] pruned_next;

  always_comb begin
    class_bad   = (cmd_class == '0) || (cmd_class > CLASS_LAST);
    a_bad       = (cmd_node_a == '0) || (cmd_node_a > NODE_LAST);
    b_bad       = (cmd_node_b == '0) || (cmd_node_b > NODE_LAST);
    a_used      = (cmd_op != OP_CLEAR);
    b_used      = (cmd_op == OP_CONNECT) || (cmd_op == OP_QUERY);
    cmd_err     = class_bad || (a_used && a_bad) || (b_used && b_bad) ||
                  ((cmd_op == OP_CONNECT) && (cmd_node_a == cmd_node_b));
    cur_present = present_m[class_q][row_q][ptr_q];
    age_next    = age_m[class_q][row_q][ptr_q] + AGE_W'(1);
    prune_hit   = cur_present && (age_next > AGE_LIMIT);
    keep_hit    = cur_present && !prune_hit;
    pruned_next = pruned_q + NODE_W'(prune_hit);
    alive_next  = alive_q || keep_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (logic [CLASS_W:0] c = '0; c <= CLASS_END; c++) begin
        for (logic [NODE_W:0] i = '0; i <= NODE_END; i++) begin
          present_m[c[CLASS_W-1:0]][i[NODE_W-1:0]] <= '0;
          age_m[c[CLASS_W-1:0]][i[NODE_W-1:0]]     <= '0;
        end
      end
      state        <= S_IDLE;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_present  <= 1'b0;
      rsp_age      <= '0;
      rsp_pruned   <= '0;
      rsp_isolated <= 1'b0;
      class_q      <= '0;
      row_q        <= '0;
      ptr_q        <= '0;
      pruned_q     <= '0;
      alive_q      <= 1'b0;
    end else begin
      // Response fields only carry data during the rsp_valid pulse.
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_present  <= 1'b0;
      rsp_age      <= '0;
      rsp_pruned   <= '0;
      rsp_isolated <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            class_q   <= cmd_class;
            row_q     <= cmd_node_a;
            if (cmd_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= S_RESP;
            end else begin
              case (cmd_op)
                OP_CONNECT: begin
                  present_m[cmd_class][cmd_node_a][cmd_node_b] <= 1'b1;
                  present_m[cmd_class][cmd_node_b][cmd_node_a] <= 1'b1;
                  age_m[cmd_class][cmd_node_a][cmd_node_b]     <= '0;
                  age_m[cmd_class][cmd_node_b][cmd_node_a]     <= '0;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
                end
                OP_QUERY: begin
                  rsp_valid   <= 1'b1;
                  rsp_present <= present_m[cmd_class][cmd_node_a][cmd_node_b];
                  rsp_age     <= age_m[cmd_class][cmd_node_a][cmd_node_b];
                  state       <= S_RESP;
                end
                OP_AGE: begin
                  ptr_q    <= NODE_W'(1);
                  pruned_q <= '0;
                  alive_q  <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_SWEEP_AGE;
                end
                default: begin
                  ptr_q <= NODE_W'(1);
                  busy  <= 1'b1;
                  state <= S_SWEEP_CLR;
                end
              endcase
            end
          end
        end

        S_SWEEP_AGE: begin
          if (prune_hit) begin
            present_m[class_q][row_q][ptr_q] <= 1'b0;
            present_m[class_q][ptr_q][row_q] <= 1'b0;
            age_m[class_q][row_q][ptr_q]     <= '0;
            age_m[class_q][ptr_q][row_q]     <= '0;
          end else if (keep_hit) begin
            age_m[class_q][row_q][ptr_q] <= age_next;
            age_m[class_q][ptr_q][row_q] <= age_next;
          end
          pruned_q <= pruned_next;
          alive_q  <= alive_next;
          if (ptr_q == NODE_LAST) begin
            busy         <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_pruned   <= pruned_next;
            rsp_isolated <= !alive_next;
            state        <= S_RESP;
          end else begin
            ptr_q <= ptr_q + NODE_W'(1);
          end
        end

        S_SWEEP_CLR: begin
          present_m[class_q][ptr_q] <= '0;
          age_m[class_q][ptr_q]     <= '0;
          for (logic [NODE_W:0] k = '0; k <= NODE_END; k++) begin
            present_m[class_q][k[NODE_W-1:0]][ptr_q] <= 1'b0;
            age_m[class_q][k[NODE_W-1:0]][ptr_q]     <= '0;
          end
          if (ptr_q == NODE_LAST) begin
            busy      <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            ptr_q <= ptr_q + NODE_W'(1);
          end
        end

        default: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
